// File: rtl/photo_hit_detector.sv
// photo_hit_detector
// Front end between the raw photoresistor array and the score logic.
// Per channel: two-flop synchronizer, then a debouncer that accepts a
// level only after DEBOUNCE_CYCLES consecutive stable samples, then a
// falling-edge (laser strike) detector that sets a pending bit.
// A lowest-index-first arbiter serves one pending strike per cycle and
// classifies it against the two active target slots (slot A wins ties).
// Events are registered one-cycle pulses with index, slot and points.
//
// Optional feature, macro MISS_REPORT_EN:
//   defined   - strikes on non-target sensors are served and pulse miss_valid.
//   undefined - miss_valid is tied low, and non-target strikes are dropped
//               from pending without consuming an arbiter cycle.
module photo_hit_detector #(
    parameter int NUM_SENSORS     = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int HIT_POINTS      = 100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] photo_array,
    input  logic [3:0]             target_a,
    input  logic [3:0]             target_b,
    output logic                   hit_valid,
    output logic                   miss_valid,
    output logic [3:0]             hit_index,
    output logic                   hit_slot,
    output logic [31:0]            points,
    output logic [15:0]            hit_count
);

    // Counter value on the cycle before acceptance; the increment that
    // would reach DEBOUNCE_CYCLES instead commits the new stable level.
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       NUM_S4      = 4'(NUM_SENSORS);
    localparam logic [31:0]      POINTS_HIT  = 32'(HIT_POINTS);
    localparam logic [15:0]      COUNT_MAX   = 16'hFFFF;

    logic [NUM_SENSORS-1:0] sync1_r;
    logic [NUM_SENSORS-1:0] sync2_r;
    logic [NUM_SENSORS-1:0] stable_r;
    logic [NUM_SENSORS-1:0] stable_d_r;
    logic [NUM_SENSORS-1:0] pending_r;
    logic [CNT_W-1:0]       cnt_r [NUM_SENSORS];

    logic [NUM_SENSORS-1:0] fall_s;
    logic [NUM_SENSORS-1:0] target_mask_s;
    logic [NUM_SENSORS-1:0] eligible_s;
    logic [NUM_SENSORS-1:0] grant_s;
    logic                   grant_valid_s;
    logic [3:0]             grant_idx_s;
    logic                   ta_valid_s;
    logic                   tb_valid_s;
    logic                   is_hit_a_s;
    logic                   is_hit_b_s;
    logic                   is_hit_s;

    // Two-flop synchronizer; resets to the unlit level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= photo_array;
            sync2_r <= sync1_r;
        end
    end

    // Per-channel debounce: count consecutive disagreeing samples, commit on the last one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_r <= '1;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (sync2_r[i] != stable_r[i]) begin
                    if (cnt_r[i] == CNT_LAST) begin
                        stable_r[i] <= sync2_r[i];
                        cnt_r[i]    <= '0;
                    end else begin
                        cnt_r[i]    <= cnt_r[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_r[i] <= '0;
                end
            end
        end
    end

    // Delayed copy of the stable level for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_d_r <= '1;
        end else begin
            stable_d_r <= stable_r;
        end
    end

    // Only 1->0 (laser arriving) is an event; 0->1 just re-arms the channel.
    assign fall_s     = stable_d_r & ~stable_r;
    assign ta_valid_s = (target_a < NUM_S4);
    assign tb_valid_s = (target_b < NUM_S4);

    // Which sensors are currently one of the active targets.
    always_comb begin
        target_mask_s = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            target_mask_s[i] = (ta_valid_s && (target_a == 4'(i))) ||
                               (tb_valid_s && (target_b == 4'(i)));
        end
    end

`ifdef MISS_REPORT_EN
    assign eligible_s = pending_r;
`else
    assign eligible_s = pending_r & target_mask_s;
`endif

    // Lowest-index pending strike wins the cycle.
    always_comb begin
        grant_idx_s = 4'd0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                grant_idx_s = 4'(i);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
    end

    assign grant_valid_s = |eligible_s;

    // One-hot of the served channel, used to clear its pending bit.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            grant_s[i] = grant_valid_s && (grant_idx_s == 4'(i));
        end
    end

    // Slot A takes priority when both slots name the same sensor.
    assign is_hit_a_s = ta_valid_s && (grant_idx_s == target_a);
    assign is_hit_b_s = !is_hit_a_s && tb_valid_s && (grant_idx_s == target_b);
    assign is_hit_s   = is_hit_a_s || is_hit_b_s;

    // Pending set: drop the served bit, merge new edges (an edge on the served bit re-sets it).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= (eligible_s & ~grant_s) | fall_s;
        end
    end

    // Registered event outputs and saturating hit counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_valid <= 1'b0;
            hit_index <= 4'd0;
            hit_slot  <= 1'b0;
            points    <= 32'd0;
            hit_count <= 16'd0;
        end else begin
            hit_valid <= grant_valid_s && is_hit_s;
            points    <= (grant_valid_s && is_hit_s) ? POINTS_HIT : 32'd0;
            if (grant_valid_s) begin
                hit_index <= grant_idx_s;
                hit_slot  <= is_hit_b_s;
            end else begin
                hit_index <= hit_index;
                hit_slot  <= hit_slot;
            end
            if (grant_valid_s && is_hit_s && (hit_count != COUNT_MAX)) begin
                hit_count <= hit_count + 16'd1;
            end else begin
                hit_count <= hit_count;
            end
        end
    end

`ifdef MISS_REPORT_EN
    // Miss pulse for strikes on sensors that are not an active target.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miss_valid <= 1'b0;
        end else begin
            miss_valid <= grant_valid_s && !is_hit_s;
        end
    end
`else
    assign miss_valid = 1'b0;
`endif

endmodule

// File: tb/tb_photo_hit_detector.sv
// Directed testbench for photo_hit_detector with DEBOUNCE_CYCLES = 4.
// Inputs change on the falling clock edge; outputs are sampled on falling
// edges. Counting from the drive point, the first rising edge is E0, so a
// lone strike pulses hit_valid at sample number 8 (E0 + 4 + 3).
module tb_photo_hit_detector;

    localparam int N = 10;

    logic         clock;
    logic         reset;
    logic [N-1:0] photo_array;
    logic [3:0]   target_a;
    logic [3:0]   target_b;
    logic         hit_valid;
    logic         miss_valid;
    logic [3:0]   hit_index;
    logic         hit_slot;
    logic [31:0]  points;
    logic [15:0]  hit_count;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int         cyc;
        logic       hit;
        logic       miss;
        logic [3:0] idx;
        logic       slot;
        logic [31:0] pts;
    } ev_t;

    ev_t evq[$];
    int  both_cnt = 0;
    int  idle_pts_cnt = 0;

    photo_hit_detector #(
        .NUM_SENSORS(N),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .HIT_POINTS(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .photo_array(photo_array),
        .target_a(target_a),
        .target_b(target_b),
        .hit_valid(hit_valid),
        .miss_valid(miss_valid),
        .hit_index(hit_index),
        .hit_slot(hit_slot),
        .points(points),
        .hit_count(hit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Step n falling edges, recording every event pulse with its sample number.
    task automatic observe(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            if (hit_valid === 1'b1 || miss_valid === 1'b1) begin
                ev_t e;
                e.cyc  = c;
                e.hit  = hit_valid;
                e.miss = miss_valid;
                e.idx  = hit_index;
                e.slot = hit_slot;
                e.pts  = points;
                evq.push_back(e);
            end
            if (hit_valid === 1'b1 && miss_valid === 1'b1) both_cnt++;
            if (hit_valid !== 1'b1 && points !== 32'd0) idle_pts_cnt++;
        end
    endtask

    task automatic test_reset();
        int nonzero;
        reset       = 1'b1;
        photo_array = 10'h3FF;
        target_a    = 4'd3;
        target_b    = 4'd15;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (hit_valid !== 1'b0 || miss_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valids: hit=%b miss=%b expected 0 0", hit_valid, miss_valid);
        end
        tests_run++;
        if (hit_index !== 4'd0 || hit_slot !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_index_slot: idx=%0d slot=%b expected 0 0", hit_index, hit_slot);
        end
        tests_run++;
        if (points !== 32'd0 || hit_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_points_count: points=%0d count=%0d expected 0 0", points, hit_count);
        end
        nonzero = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (hit_valid !== 1'b0 || miss_valid !== 1'b0 || hit_index !== 4'd0 ||
                hit_slot !== 1'b0 || points !== 32'd0 || hit_count !== 16'd0) nonzero++;
        end
        tests_run++;
        if (nonzero !== 0) begin
            tests_failed++;
            $display("FAIL reset_idle_20: nonzero cycles=%0d expected 0", nonzero);
        end
    endtask

    task automatic test_single_hit();
        evq.delete();
        photo_array[3] = 1'b0;
        observe(20);
        tests_run++;
        if (evq.size() !== 1) begin
            tests_failed++;
            $display("FAIL single_count: events=%0d expected 1", evq.size());
        end else begin
            tests_run++;
            if (evq[0].cyc !== 8 || evq[0].hit !== 1'b1) begin
                tests_failed++;
                $display("FAIL single_latency: cyc=%0d hit=%b expected 8 1", evq[0].cyc, evq[0].hit);
            end
            tests_run++;
            if (evq[0].idx !== 4'd3 || evq[0].slot !== 1'b0 || evq[0].pts !== 32'd100) begin
                tests_failed++;
                $display("FAIL single_fields: idx=%0d slot=%b pts=%0d expected 3 0 100",
                         evq[0].idx, evq[0].slot, evq[0].pts);
            end
        end
        tests_run++;
        if (hit_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL single_hit_count: got %0d expected 1", hit_count);
        end
        tests_run++;
        if (hit_index !== 4'd3) begin
            tests_failed++;
            $display("FAIL single_index_hold: got %0d expected 3", hit_index);
        end
    endtask

    task automatic test_glitch();
        evq.delete();
        photo_array[3] = 1'b1;
        observe(10);
        photo_array[3] = 1'b0;
        repeat (2) @(negedge clock);
        photo_array[3] = 1'b1;
        observe(15);
        tests_run++;
        if (evq.size() !== 0) begin
            tests_failed++;
            $display("FAIL glitch_no_event: events=%0d expected 0", evq.size());
        end
        evq.delete();
        photo_array[3] = 1'b0;
        observe(20);
        tests_run++;
        if (evq.size() !== 1) begin
            tests_failed++;
            $display("FAIL rehit_count: events=%0d expected 1", evq.size());
        end else begin
            tests_run++;
            if (evq[0].cyc !== 8 || evq[0].idx !== 4'd3 || evq[0].hit !== 1'b1) begin
                tests_failed++;
                $display("FAIL rehit_fields: cyc=%0d idx=%0d hit=%b expected 8 3 1",
                         evq[0].cyc, evq[0].idx, evq[0].hit);
            end
        end
        tests_run++;
        if (hit_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL rehit_hit_count: got %0d expected 2", hit_count);
        end
        evq.delete();
        photo_array[3] = 1'b1;
        observe(10);
        tests_run++;
        if (evq.size() !== 0) begin
            tests_failed++;
            $display("FAIL release_no_event: events=%0d expected 0", evq.size());
        end
    endtask

    task automatic test_back_to_back();
        evq.delete();
        target_b = 4'd7;
        photo_array[3] = 1'b0;
        photo_array[7] = 1'b0;
        observe(20);
        tests_run++;
        if (evq.size() !== 2) begin
            tests_failed++;
            $display("FAIL b2b_count: events=%0d expected 2", evq.size());
        end else begin
            tests_run++;
            if (evq[0].cyc !== 8 || evq[0].idx !== 4'd3 || evq[0].slot !== 1'b0 || evq[0].hit !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_first: cyc=%0d idx=%0d slot=%b expected 8 3 0",
                         evq[0].cyc, evq[0].idx, evq[0].slot);
            end
            tests_run++;
            if (evq[1].cyc !== 9 || evq[1].idx !== 4'd7 || evq[1].slot !== 1'b1 || evq[1].hit !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_second: cyc=%0d idx=%0d slot=%b expected 9 7 1",
                         evq[1].cyc, evq[1].idx, evq[1].slot);
            end
        end
        tests_run++;
        if (hit_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL b2b_hit_count: got %0d expected 4", hit_count);
        end
        photo_array[3] = 1'b1;
        photo_array[7] = 1'b1;
        observe(10);
    endtask

    task automatic test_same_target_and_miss();
        evq.delete();
        target_a = 4'd5;
        target_b = 4'd5;
        photo_array[5] = 1'b0;
        observe(20);
        tests_run++;
        if (evq.size() !== 1) begin
            tests_failed++;
            $display("FAIL tie_count: events=%0d expected 1", evq.size());
        end else begin
            tests_run++;
            if (evq[0].idx !== 4'd5 || evq[0].slot !== 1'b0 || evq[0].hit !== 1'b1 || evq[0].cyc !== 8) begin
                tests_failed++;
                $display("FAIL tie_slot_a: idx=%0d slot=%b cyc=%0d expected 5 0 8",
                         evq[0].idx, evq[0].slot, evq[0].cyc);
            end
        end
        photo_array[5] = 1'b1;
        observe(10);
        evq.delete();
        photo_array[2] = 1'b0;
        observe(20);
`ifdef MISS_REPORT_EN
        tests_run++;
        if (evq.size() !== 1) begin
            tests_failed++;
            $display("FAIL miss_count: events=%0d expected 1", evq.size());
        end else begin
            tests_run++;
            if (evq[0].miss !== 1'b1 || evq[0].hit !== 1'b0 || evq[0].idx !== 4'd2 || evq[0].cyc !== 8) begin
                tests_failed++;
                $display("FAIL miss_fields: miss=%b hit=%b idx=%0d cyc=%0d expected 1 0 2 8",
                         evq[0].miss, evq[0].hit, evq[0].idx, evq[0].cyc);
            end
        end
`else
        tests_run++;
        if (evq.size() !== 0) begin
            tests_failed++;
            $display("FAIL miss_suppressed: events=%0d expected 0", evq.size());
        end
`endif
        tests_run++;
        if (hit_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL miss_not_counted: got %0d expected 5", hit_count);
        end
        photo_array[2] = 1'b1;
        observe(10);
        target_a = 4'd3;
        target_b = 4'd15;
    endtask

    task automatic test_reset_mid();
        evq.delete();
        photo_array[3] = 1'b0;
        observe(6);
        reset = 1'b1;
        #1;
        tests_run++;
        if (hit_count !== 16'd0 || hit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_clear: count=%0d hit=%b expected 0 0", hit_count, hit_valid);
        end
        observe(2);
        tests_run++;
        if (evq.size() !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_pulse: events=%0d expected 0", evq.size());
        end
        reset = 1'b0;
        evq.delete();
        observe(20);
        tests_run++;
        if (evq.size() !== 1) begin
            tests_failed++;
            $display("FAIL redetect_count: events=%0d expected 1", evq.size());
        end else begin
            tests_run++;
            if (evq[0].cyc !== 8 || evq[0].idx !== 4'd3 || evq[0].hit !== 1'b1) begin
                tests_failed++;
                $display("FAIL redetect_fields: cyc=%0d idx=%0d expected 8 3", evq[0].cyc, evq[0].idx);
            end
        end
        tests_run++;
        if (hit_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL redetect_hit_count: got %0d expected 1", hit_count);
        end
        photo_array[3] = 1'b1;
        observe(10);
    endtask

    task automatic test_saturation();
        force dut.hit_count = 16'hFFFF;
        #1;
        release dut.hit_count;
        @(negedge clock);
        tests_run++;
        if (hit_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_preload: got %h expected ffff", hit_count);
        end
        evq.delete();
        photo_array[3] = 1'b0;
        observe(20);
        tests_run++;
        if (evq.size() !== 1) begin
            tests_failed++;
            $display("FAIL sat_event: events=%0d expected 1", evq.size());
        end
        tests_run++;
        if (hit_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_hold: got %h expected ffff", hit_count);
        end
    endtask

    initial begin
        reset       = 1'b1;
        photo_array = 10'h3FF;
        target_a    = 4'd3;
        target_b    = 4'd15;
        test_reset();
        test_single_hit();
        test_glitch();
        test_back_to_back();
        test_same_target_and_miss();
        test_reset_mid();
        test_saturation();
        tests_run++;
        if (both_cnt !== 0) begin
            tests_failed++;
            $display("FAIL hit_miss_exclusive: both-high cycles=%0d expected 0", both_cnt);
        end
        tests_run++;
        if (idle_pts_cnt !== 0) begin
            tests_failed++;
            $display("FAIL points_idle_zero: nonzero idle cycles=%0d expected 0", idle_pts_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
